// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 16-bit pipelined CPU.
// Owns the PC, fetches over a req/ready I-cache handshake and keeps one
// early-returned instruction in a skid buffer while ID is stalled.
module fetch_stage #(
    parameter int unsigned          WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 imem_ready,
    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_pc1
);

    localparam int unsigned W = WORD_SIZE;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   shadow_q, shadow_d;       // address of the miss being drained
    logic           halt_pend_q, halt_pend_d; // drain ends in HALT instead of REQ
    logic           skid_full_q, skid_full_d;
    logic [W-1:0]   skid_inst_q, skid_inst_d;
    logic [W-1:0]   skid_pc_q, skid_pc_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   inst_q, inst_d;
    logic [W-1:0]   id_pc_q, id_pc_d;
    logic [W-1:0]   id_pc1_q, id_pc1_d;

    logic           xfer;
    logic           miss;
    logic           if_id_free;
    logic           flush;

    assign xfer       = imem_req & imem_ready;
    assign miss       = imem_req & ~imem_ready;
    assign if_id_free = ~valid_q | ~stall;
    assign flush      = (state_q != ST_HALT) & (redirect | halt);

    assign if_id_valid = valid_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc1   = id_pc1_q;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            shadow_q    <= '0;
            halt_pend_q <= 1'b0;
            skid_full_q <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            valid_q     <= 1'b0;
            inst_q      <= '0;
            id_pc_q     <= '0;
            id_pc1_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            shadow_q    <= shadow_d;
            halt_pend_q <= halt_pend_d;
            skid_full_q <= skid_full_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            id_pc_q     <= id_pc_d;
            id_pc1_q    <= id_pc1_d;
        end
    end

    // Next-state: an outstanding miss must drain through DISCARD before REQ/HALT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    state_d = miss ? ST_DISCARD : ST_REQ;
                end else if (halt) begin
                    state_d = miss ? ST_DISCARD : ST_HALT;
                end
            end
            ST_DISCARD: begin
                if (imem_ready) begin
                    state_d = (!redirect && (halt || halt_pend_q)) ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_REQ;
        endcase
    end

    // Fetch request: drained address while discarding, else PC unless skid is full
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (reset_n) begin
            unique case (state_q)
                ST_DISCARD: begin
                    imem_req  = 1'b1;
                    imem_addr = shadow_q;
                end
                ST_REQ:  imem_req = ~skid_full_q;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // PC, skid buffer and IF/ID updates
    always_comb begin
        pc_d        = pc_q;
        shadow_d    = shadow_q;
        halt_pend_d = halt_pend_q;
        skid_full_d = skid_full_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        id_pc_d     = id_pc_q;
        id_pc1_d    = id_pc1_q;

        if (state_q != ST_HALT) begin
            if (redirect) begin
                halt_pend_d = 1'b0;
            end else if (halt) begin
                halt_pend_d = 1'b1;
            end
        end
        if (state_d != ST_DISCARD) begin
            halt_pend_d = 1'b0;
        end
        if (state_q == ST_REQ && state_d == ST_DISCARD) begin
            shadow_d = pc_q;
        end

        if (flush) begin
            valid_d     = 1'b0;
            inst_d      = '0;
            skid_full_d = 1'b0;
            if (redirect) begin
                pc_d = redirect_pc;
            end
        end else if (state_q == ST_REQ) begin
            if (xfer) begin
                pc_d = W'(pc_q + W'(1));
                if (if_id_free) begin
                    valid_d  = 1'b1;
                    inst_d   = imem_rdata;
                    id_pc_d  = pc_q;
                    id_pc1_d = W'(pc_q + W'(1));
                end else begin
                    skid_full_d = 1'b1;
                    skid_inst_d = imem_rdata;
                    skid_pc_d   = pc_q;
                end
            end else if (if_id_free && skid_full_q) begin
                valid_d     = 1'b1;
                inst_d      = skid_inst_q;
                id_pc_d     = skid_pc_q;
                id_pc1_d    = W'(skid_pc_q + W'(1));
                skid_full_d = 1'b0;
            end else if (if_id_free) begin
                valid_d = 1'b0;
                inst_d  = '0;
            end
        end else begin
            valid_d = 1'b0;
            inst_d  = '0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: one table row per clock cycle.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_id_valid (if_id_valid),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_pc1   (if_id_pc1)
    );

    // One cycle: inputs driven for the cycle, outputs expected before its rising edge
    typedef struct {
        logic        rn, st, rd;
        logic [15:0] rpc;
        logic        hl, rdy;
        logic [15:0] rdata;
        logic        req;
        logic [15:0] addr;
        logic        v;
        logic [15:0] inst, pc, pc1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rn, logic st, logic rd, logic [15:0] rpc,
                                logic hl, logic rdy, logic [15:0] rdata,
                                logic req, logic [15:0] addr, logic v,
                                logic [15:0] inst, logic [15:0] pc, logic [15:0] pc1);
        vec_t r;
        r.rn = rn; r.st = st; r.rd = rd; r.rpc = rpc; r.hl = hl; r.rdy = rdy;
        r.rdata = rdata; r.req = req; r.addr = addr; r.v = v;
        r.inst = inst; r.pc = pc; r.pc1 = pc1;
        return r;
    endfunction

    task automatic chk(input string name, input int step,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int step);
        @(negedge clk);
        reset_n     = t.rn;
        stall       = t.st;
        redirect    = t.rd;
        redirect_pc = t.rpc;
        halt        = t.hl;
        imem_ready  = t.rdy;
        imem_rdata  = t.rdata;
        #1;
        chk("imem_req",    step, 16'(imem_req),    16'(t.req));
        chk("imem_addr",   step, imem_addr,        t.addr);
        chk("if_id_valid", step, 16'(if_id_valid), 16'(t.v));
        chk("if_id_inst",  step, if_id_inst,       t.inst);
        chk("if_id_pc",    step, if_id_pc,         t.pc);
        chk("if_id_pc1",   step, if_id_pc1,        t.pc1);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);

        //            rn st rd rpc      hl rdy rdata     req addr     v  inst     pc       pc1
        // reset
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        // always-ready streaming
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1001, 1, 16'h0001, 1, 16'h1000, 16'h0000, 16'h0001));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1002, 1, 16'h0002, 1, 16'h1001, 16'h0001, 16'h0002));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1234, 1, 16'h0003, 1, 16'h1002, 16'h0002, 16'h0003));
        // stall 3 cycles: addr 4 goes to skid, no request for 5
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h5678, 1, 16'h0004, 1, 16'h1234, 16'h0003, 16'h0004));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'hDEAD, 0, 16'h0005, 1, 16'h1234, 16'h0003, 16'h0004));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'hDEAD, 0, 16'h0005, 1, 16'h1234, 16'h0003, 16'h0004));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 0, 16'h0005, 1, 16'h1234, 16'h0003, 16'h0004));
        // skid drained; addr 5 waits 3 cycles on ready
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDEAD, 1, 16'h0005, 1, 16'h5678, 16'h0004, 16'h0005));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDEAD, 1, 16'h0005, 0, 16'h0000, 16'h0004, 16'h0005));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDEAD, 1, 16'h0005, 0, 16'h0000, 16'h0004, 16'h0005));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hBEEF, 1, 16'h0005, 0, 16'h0000, 16'h0004, 16'h0005));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h2006, 1, 16'h0006, 1, 16'hBEEF, 16'h0005, 16'h0006));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h2007, 1, 16'h0007, 1, 16'h2006, 16'h0006, 16'h0007));
        // miss at 8 with redirect to 0x0040: 8 held, data dropped
        tbl.push_back(mk(1, 0, 1, 16'h0040, 0, 0, 16'hDEAD, 1, 16'h0008, 1, 16'h2007, 16'h0007, 16'h0008));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDEAD, 1, 16'h0008, 0, 16'h0000, 16'h0007, 16'h0008));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h0008, 0, 16'h0000, 16'h0007, 16'h0008));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h3040, 1, 16'h0040, 0, 16'h0000, 16'h0007, 16'h0008));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h3041, 1, 16'h0041, 1, 16'h3040, 16'h0040, 16'h0041));
        // redirect + halt together: redirect wins
        tbl.push_back(mk(1, 0, 1, 16'h0100, 1, 1, 16'hDEAD, 1, 16'h0042, 1, 16'h3041, 16'h0041, 16'h0042));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h4100, 1, 16'h0100, 0, 16'h0000, 16'h0041, 16'h0042));
        // halt during a miss: drain, then HALT ignores redirect
        tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'hDEAD, 1, 16'h0101, 1, 16'h4100, 16'h0100, 16'h0101));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDEAD, 1, 16'h0101, 0, 16'h0000, 16'h0100, 16'h0101));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h0101, 0, 16'h0000, 16'h0100, 16'h0101));
        tbl.push_back(mk(1, 0, 1, 16'h0200, 0, 1, 16'hDEAD, 0, 16'h0101, 0, 16'h0000, 16'h0100, 16'h0101));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 0, 16'h0101, 0, 16'h0000, 16'h0100, 16'h0101));
        // one-cycle reset leaves HALT
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 0, 16'h0101, 0, 16'h0000, 16'h0100, 16'h0101));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h1000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
        // redirect to 0xFFFF: pc1 and next address wrap
        tbl.push_back(mk(1, 0, 1, 16'hFFFF, 0, 1, 16'hDEAD, 1, 16'h0001, 1, 16'h1000, 16'h0000, 16'h0001));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h5FFF, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0001));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h5000, 1, 16'h0000, 1, 16'h5FFF, 16'hFFFF, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'hDEAD, 1, 16'h0001, 1, 16'h5000, 16'h0000, 16'h0001));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Redirect twice during a drain: the later target wins
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0010; imem_ready = 1'b0; #1;
        chk("dbl_redir_req0", 100, 16'(imem_req), 16'h0001);
        chk("dbl_redir_addr0", 100, imem_addr, 16'h0001);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0020; imem_ready = 1'b0; #1;
        chk("dbl_redir_addr1", 101, imem_addr, 16'h0001);
        chk("dbl_redir_valid1", 101, 16'(if_id_valid), 16'h0000);
        @(negedge clk);
        redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 16'hDEAD; #1;
        chk("dbl_redir_addr2", 102, imem_addr, 16'h0001);
        @(negedge clk);
        imem_rdata = 16'h6020; #1;
        chk("dbl_redir_target", 103, imem_addr, 16'h0020);
        chk("dbl_redir_valid3", 103, 16'(if_id_valid), 16'h0000);

        // Halt with the request completing that cycle goes straight to HALT
        @(negedge clk);
        halt = 1'b1; imem_rdata = 16'hDEAD; #1;
        chk("halt_hit_inst", 104, if_id_inst, 16'h6020);
        chk("halt_hit_pc1", 104, if_id_pc1, 16'h0021);
        @(negedge clk);
        halt = 1'b0; #1;
        chk("halt_hit_req", 105, 16'(imem_req), 16'h0000);
        chk("halt_hit_valid", 105, 16'(if_id_valid), 16'h0000);
        @(negedge clk);
        #1;
        chk("halt_hold_req", 106, 16'(imem_req), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
